// File: rtl/dino_player_ctrl_pkg.sv
// Shared dino definitions: sprite-select state codes used by the player
// controller and the sprite ROM, plus physics limits.
package dino_player_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int Y_W     = 6;
  localparam int V_W     = 6;
  localparam int CNT_W   = 4;

  localparam logic [STATE_W-1:0] ST_RESTART   = 3'b000;
  localparam logic [STATE_W-1:0] ST_JUMPING   = 3'b001;
  localparam logic [STATE_W-1:0] ST_RUNNING_1 = 3'b010;
  localparam logic [STATE_W-1:0] ST_RUNNING_2 = 3'b011;
  localparam logic [STATE_W-1:0] ST_DUCKING   = 3'b100;
  localparam logic [STATE_W-1:0] ST_GAME_OVER = 3'b101;

  localparam logic [Y_W-1:0] Y_MAX = 6'd63;

  function automatic logic is_running(input logic [STATE_W-1:0] s);
    return (s == ST_RUNNING_1) || (s == ST_RUNNING_2);
  endfunction

endpackage

// File: rtl/dino_jump_phys.sv
// Vertical jump physics: height/velocity registers, landing detect and
// height saturation. Advances only when step is asserted.
module dino_jump_phys
  import dino_player_ctrl_pkg::*;
#(
  parameter int unsigned JUMP_V0 = 6,
  parameter int unsigned GRAVITY = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           start,
  input  logic           step,
  output logic [Y_W-1:0] y,
  output logic           landed
);

  localparam logic signed [V_W-1:0] V_INIT = V_W'(JUMP_V0);
  localparam logic signed [V_W-1:0] V_MIN  = 6'b10_0000;

  logic signed [V_W-1:0] v;
  logic signed [7:0]     y_sum;
  logic signed [6:0]     v_dec;
  logic [Y_W-1:0]        y_next;
  logic signed [V_W-1:0] v_next;

  // 8-bit signed sum covers -32..94, so both landing and overflow are visible
  always_comb begin
    y_sum  = $signed({2'b00, y}) + $signed({{2{v[V_W-1]}}, v});
    landed = (y_sum <= 8'sd0);
    y_next = (y_sum > 8'sd63) ? Y_MAX : y_sum[Y_W-1:0];
    v_dec  = $signed({v[V_W-1], v}) - $signed(7'(GRAVITY));
    v_next = (v_dec < -7'sd32) ? V_MIN : v_dec[V_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
      v <= '0;
    end else if (clear) begin
      y <= '0;
      v <= '0;
    end else if (start) begin
      y <= '0;
      v <= V_INIT;
    end else if (step) begin
      if (landed) begin
        y <= '0;
        v <= '0;
      end else begin
        y <= y_next;
        v <= v_next;
      end
    end
  end

endmodule

// File: rtl/dino_player_ctrl.sv
// Dino player controller: per-frame FSM selecting the sprite, running
// animation counter and jump arming; physics lives in dino_jump_phys.
module dino_player_ctrl
  import dino_player_ctrl_pkg::*;
#(
  parameter int unsigned JUMP_V0 = 6,
  parameter int unsigned GRAVITY = 1,
  parameter int unsigned RUN_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_frame_tick,
  input  logic               i_start,
  input  logic               i_jump,
  input  logic               i_duck,
  input  logic               i_collision,
  output logic [STATE_W-1:0] o_player_state,
  output logic [Y_W-1:0]     o_player_y
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_DIV - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               phys_clear, phys_start, phys_step;
  logic               landed;
  logic [Y_W-1:0]     y;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    phys_clear = 1'b0;
    phys_start = 1'b0;
    phys_step  = 1'b0;
    if (i_frame_tick) begin
      // A low sample re-arms; transitions below override when they disarm
      if (!i_jump) armed_d = 1'b1;
      case (state_q)
        ST_RESTART: begin
          if (i_start) begin
            state_d    = ST_RUNNING_1;
            cnt_d      = '0;
            armed_d    = 1'b0;
            phys_clear = 1'b1;
          end
        end
        ST_RUNNING_1, ST_RUNNING_2: begin
          if (i_collision) begin
            state_d = ST_GAME_OVER;
          end else if (armed_q && i_jump) begin
            state_d    = ST_JUMPING;
            cnt_d      = '0;
            armed_d    = 1'b0;
            phys_start = 1'b1;
          end else if (i_duck) begin
            state_d = ST_DUCKING;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = is_running(state_q) && (state_q == ST_RUNNING_1)
                      ? ST_RUNNING_2 : ST_RUNNING_1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DUCKING: begin
          if (i_collision) begin
            state_d = ST_GAME_OVER;
          end else if (armed_q && i_jump) begin
            state_d    = ST_JUMPING;
            cnt_d      = '0;
            armed_d    = 1'b0;
            phys_start = 1'b1;
          end else if (!i_duck) begin
            state_d = ST_RUNNING_1;
            cnt_d   = '0;
          end
        end
        ST_JUMPING: begin
          // Buttons are ignored in the air, including for arming
          armed_d = armed_q;
          if (i_collision) begin
            state_d = ST_GAME_OVER;
          end else begin
            phys_step = 1'b1;
            if (landed) begin
              state_d = i_duck ? ST_DUCKING : ST_RUNNING_1;
              cnt_d   = '0;
              armed_d = 1'b0;
            end
          end
        end
        ST_GAME_OVER: begin
          if (i_start) begin
            state_d    = ST_RESTART;
            cnt_d      = '0;
            armed_d    = 1'b0;
            phys_clear = 1'b1;
          end
        end
        default: begin
          state_d    = ST_RESTART;
          cnt_d      = '0;
          armed_d    = 1'b0;
          phys_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESTART;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  dino_jump_phys #(
    .JUMP_V0(JUMP_V0),
    .GRAVITY(GRAVITY)
  ) u_phys (
    .clk   (clk),
    .rst   (rst),
    .clear (phys_clear),
    .start (phys_start),
    .step  (phys_step),
    .y     (y),
    .landed(landed)
  );

  assign o_player_state = state_q;
  assign o_player_y     = y;

endmodule

// File: tb/tb_dino_player_ctrl.sv
// Scoreboard bench for dino_player_ctrl: each frame tick pushes the expected
// state/height; a monitor pops and compares after the DUT updates.
module tb_dino_player_ctrl;
  import dino_player_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] y;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_frame_tick = 1'b0;
  logic       i_start = 1'b0;
  logic       i_jump = 1'b0;
  logic       i_duck = 1'b0;
  logic       i_collision = 1'b0;
  logic [2:0] o_player_state;
  logic [5:0] o_player_y;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t last_exp = '0;
  bit   tick_q = 1'b0;

  dino_player_ctrl #(.JUMP_V0(6), .GRAVITY(1), .RUN_DIV(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_frame_tick  (i_frame_tick),
    .i_start       (i_start),
    .i_jump        (i_jump),
    .i_duck        (i_duck),
    .i_collision   (i_collision),
    .o_player_state(o_player_state),
    .o_player_y    (o_player_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tick_q <= i_frame_tick;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare after every tick, and verify outputs hold between ticks
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_exp = '{st: ST_RESTART, y: 6'd0};
    end else if (tick_q) begin
      if (exp_q.size() == 0) begin
        chk("tick_without_expectation", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("tick_state", int'(o_player_state), int'(e.st));
        chk("tick_y", int'(o_player_y), int'(e.y));
        last_exp = e;
      end
    end else begin
      chk("hold_state", int'(o_player_state), int'(last_exp.st));
      chk("hold_y", int'(o_player_y), int'(last_exp.y));
    end
  end

  task automatic do_tick(input bit s, input bit j, input bit d, input bit c,
                         input logic [2:0] es, input logic [5:0] ey);
    @(negedge clk);
    i_start = s; i_jump = j; i_duck = d; i_collision = c;
    i_frame_tick = 1'b1;
    exp_q.push_back('{st: es, y: ey});
    @(negedge clk);
    i_frame_tick = 1'b0;
    // Noise between ticks must have no effect
    i_start = 1'b1; i_jump = 1'b1; i_duck = 1'b1; i_collision = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int arc[12];
    arc = '{6, 11, 15, 18, 20, 21, 21, 20, 18, 15, 11, 6};

    #1;
    chk("reset_state", int'(o_player_state), int'(ST_RESTART));
    chk("reset_y", int'(o_player_y), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle and collision ignored in RESTART, then start
    do_tick(0, 0, 0, 0, ST_RESTART, 0);
    do_tick(0, 0, 0, 1, ST_RESTART, 0);
    do_tick(1, 0, 0, 0, ST_RUNNING_1, 0);

    // Run animation: 4 ticks per phase
    do_tick(0, 0, 0, 0, ST_RUNNING_1, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_1, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_1, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_2, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_2, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_2, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_2, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_1, 0);

    // Jump pulse; duck during flight ignored
    do_tick(0, 1, 0, 0, ST_JUMPING, 0);
    for (int i = 0; i < 12; i++)
      do_tick(0, 0, (i % 3) == 1, 0, ST_JUMPING, 6'(arc[i]));
    do_tick(0, 0, 0, 0, ST_RUNNING_1, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_1, 0);

    // Jump held through landing, land while ducking
    do_tick(0, 1, 0, 0, ST_JUMPING, 0);
    for (int i = 0; i < 12; i++)
      do_tick(0, 1, 0, 0, ST_JUMPING, 6'(arc[i]));
    do_tick(0, 1, 1, 0, ST_DUCKING, 0);
    do_tick(0, 1, 1, 0, ST_DUCKING, 0);
    do_tick(0, 1, 0, 0, ST_RUNNING_1, 0);
    do_tick(0, 1, 0, 0, ST_RUNNING_1, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_1, 0);
    do_tick(0, 1, 0, 0, ST_JUMPING, 0);

    // Collision at y=18 freezes, GAME_OVER ignores collision, restart
    for (int i = 0; i < 4; i++)
      do_tick(0, 0, 0, 0, ST_JUMPING, 6'(arc[i]));
    do_tick(0, 0, 0, 1, ST_GAME_OVER, 18);
    do_tick(0, 0, 0, 0, ST_GAME_OVER, 18);
    do_tick(0, 0, 0, 1, ST_GAME_OVER, 18);
    do_tick(1, 0, 0, 0, ST_RESTART, 0);
    do_tick(1, 0, 0, 0, ST_RUNNING_1, 0);

    // Duck 3 ticks then release; counter cleared on return
    do_tick(0, 0, 1, 0, ST_DUCKING, 0);
    do_tick(0, 0, 1, 0, ST_DUCKING, 0);
    do_tick(0, 0, 1, 0, ST_DUCKING, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_1, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_1, 0);

    // Collision while running
    do_tick(0, 0, 0, 1, ST_GAME_OVER, 0);
    do_tick(1, 0, 0, 0, ST_RESTART, 0);
    do_tick(1, 0, 0, 0, ST_RUNNING_1, 0);
    do_tick(0, 0, 0, 0, ST_RUNNING_1, 0);
    do_tick(0, 1, 0, 0, ST_JUMPING, 0);
    do_tick(0, 0, 0, 0, ST_JUMPING, 6);
    do_tick(0, 0, 0, 0, ST_JUMPING, 11);

    // Asynchronous reset mid-jump, no tick involved
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", int'(o_player_state), int'(ST_RESTART));
    chk("async_rst_y", int'(o_player_y), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First tick after reset processed; jump from DUCKING
    do_tick(1, 0, 0, 0, ST_RUNNING_1, 0);
    do_tick(0, 0, 1, 0, ST_DUCKING, 0);
    do_tick(0, 1, 1, 0, ST_JUMPING, 0);
    do_tick(0, 0, 0, 0, ST_JUMPING, 6);
    do_tick(0, 0, 0, 1, ST_GAME_OVER, 6);
    do_tick(1, 0, 0, 0, ST_RESTART, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
